// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog_if
// Purpose  : Control/status bundle for the multi-channel programmable clock
//            divider. The controller side uses the master modport; the
//            divider itself uses the slave modport.
// Signals  : en, restart, load      - per-channel controls (NCH bits each)
//            div_in                 - packed divisors, channel i at [i*WIDTH +: WIDTH]
//            clkOut, tick, load_done- per-channel registered status (NCH bits)
// Revision : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2
);
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       restart;
    logic [NCH-1:0]       load;
    logic [NCH*WIDTH-1:0] div_in;
    logic [NCH-1:0]       clkOut;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       load_done;

    modport master (
        output en, restart, load, div_in,
        input  clkOut, tick, load_done
    );

    modport slave (
        input  en, restart, load, div_in,
        output clkOut, tick, load_done
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog
// Purpose  : NCH independent programmable clock dividers. Each channel counts
//            0..D on enabled cycles; on reaching D it wraps to 0, toggles
//            clkOut and pulses tick. New divisors are staged as "pending" and
//            take effect at a terminal count, on a restart, or on the next
//            edge while the channel is disabled.
// Ports    : clk    - system clock, rising edge
//            reset  - asynchronous, active-low reset
//            bus    - clk_div_prog_if slave modport (controls and status)
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int WIDTH       = 32,
    parameter int NCH         = 2,
    parameter int DEFAULT_DIV = 10000000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    clk_div_prog_if.slave     bus
);

    localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q,  cnt_d;
        logic [WIDTH-1:0] div_q,  div_d;
        logic [WIDTH-1:0] pdiv_q, pdiv_d;
        logic             pend_q, pend_d;
        logic             clk_q,  clk_d;
        logic             tick_q, tick_d;
        logic             ld_q,   ld_d;
        logic [WIDTH-1:0] din;
        logic             term;
        logic             apply;

        assign din  = bus.div_in[i*WIDTH +: WIDTH];
        assign term = bus.en[i] && (cnt_q == div_q);
        // A staged divisor becomes active at any point where the count is not
        // mid-period: restart, terminal count, or while the channel is idle.
        assign apply = pend_q && (bus.restart[i] || term || !bus.en[i]);

        always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            pdiv_d = pdiv_q;
            pend_d = pend_q;
            clk_d  = clk_q;
            tick_d = 1'b0;
            ld_d   = 1'b0;

            if (apply) begin
                div_d  = pdiv_q;
                pend_d = 1'b0;
                ld_d   = 1'b1;
            end

            if (bus.restart[i]) begin
                cnt_d = '0;
                clk_d = 1'b0;
            end else if (term) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
            end else if (bus.en[i]) begin
                cnt_d = cnt_q + C_ONE;
            end

            // Loaded last so a same-cycle load always lands in the staging
            // register, after any older pending value has been consumed above.
            if (bus.load[i]) begin
                pdiv_d = din;
                pend_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q  <= '0;
                div_q  <= C_DEFAULT_DIV;
                pdiv_q <= '0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                ld_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
                ld_q   <= ld_d;
            end
        end

        assign bus.clkOut[i]    = clk_q;
        assign bus.tick[i]      = tick_q;
        assign bus.load_done[i] = ld_q;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 32: width of each channel's divisor and counter.
REQ-002 Parameter NCH, default 2: number of independent divider channels.
REQ-003 Parameter DEFAULT_DIV, default 10000000: divisor loaded into every channel at reset.
REQ-004 Port clk, input, 1: the single system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port en, input, NCH: per-channel count enable.
REQ-007 Port restart, input, NCH: per-channel synchronous phase restart.
REQ-008 Port load, input, NCH: per-channel single-cycle divisor load strobe.
REQ-009 Port div_in, input, NCH*WIDTH: packed new divisors; channel i uses bits [i*WIDTH +: WIDTH].
REQ-010 Port clkOut, output, NCH: per-channel divided clock, toggling on each terminal count.
REQ-011 Port tick, output, NCH: per-channel one-cycle pulse on each terminal count.
REQ-012 Port load_done, output, NCH: per-channel one-cycle pulse when a pending divisor becomes active.

Function
REQ-013 Each channel shall hold three registers: cnt, active divisor D, and a pending divisor with a pend flag; channels share no state.
REQ-014 With en=1 and cnt!=D, the channel shall increment cnt by 1.
REQ-015 With en=1 and cnt==D (terminal), the channel shall set cnt to 0, invert clkOut and assert tick for exactly that following cycle.
REQ-016 Resulting periods: clkOut period 2*(D+1) clk cycles at 50% duty; tick period D+1.
REQ-017 D=0 shall be legal: tick held high continuously while en=1, and clkOut toggles every cycle.
REQ-018 With en=0, cnt and clkOut shall hold, tick shall be 0, and no terminal event occurs.
REQ-019 load=1 shall capture the channel's div_in slice into pending and set pend=1; D is not changed in that cycle.
REQ-020 A load while pend=1 shall overwrite pending (last write wins), with no extra load_done.
REQ-021 If pend=1 at a terminal event, the channel shall copy pending into D, clear pend, set cnt to 0 and pulse load_done in the same cycle as tick.
REQ-022 If pend=1 and en=0, the channel shall apply the pending divisor on the next clock edge, clear pend, pulse load_done, leave cnt unchanged and leave clkOut unchanged.
REQ-023 If load and a terminal event occur in the same cycle, the terminal event shall apply the previously pending value, if any, and the new value becomes pending for the next terminal.
REQ-024 restart=1 shall set cnt=0, clkOut=0 and tick=0. If pend=1, it shall also apply pending to D and pulse load_done. restart overrides en and any terminal event in that cycle.
REQ-025 If restart and load are asserted together, the loaded value shall become pending only; it is not applied in that cycle.
REQ-026 cnt compare shall be an exact WIDTH-bit equality; cnt shall never exceed D, so no wrap-around beyond D is possible.
REQ-027 tick and load_done shall be registered outputs, with no combinational path from any input to any output.

Reset
REQ-028 With reset=0, asynchronously and for every channel: cnt=0, D=DEFAULT_DIV, pending=0, pend=0, clkOut=0, tick=0, load_done=0.
REQ-029 Reset asserted mid-count or with a load pending shall discard the pending divisor without pulsing load_done.
REQ-030 After reset deasserts, the first terminal event shall occur on the (DEFAULT_DIV+1)-th enabled clock edge.

Verification
REQ-031 WIDTH=8, DEFAULT_DIV=3, en=1 -> tick every 4 cycles; clkOut period 8 cycles, first rising edge 4 edges after reset release.
REQ-032 Load div_in=1 at cnt=1 with D=3 -> pend=1; at the next terminal, load_done and tick pulse together; tick period becomes 2 thereafter.
REQ-033 Load 5 and then 2 before the terminal -> a single load_done, and D=2 after that terminal.
REQ-034 en=0 for 10 cycles at cnt=2 -> cnt and clkOut frozen, tick=0; with a pending load during that freeze, load_done fires one cycle later and cnt remains 2.
REQ-035 restart together with load at a terminal cycle -> cnt=0, clkOut=0, tick=0; the new value becomes pending and no load_done occurs in that cycle.
REQ-036 NCH=2, channel 0 with D=0 and channel 1 with D=4, reset asserted mid-run -> all outputs 0 immediately; channels then run independently after release.
